// File: rtl/alineador_mantisas_pipe.sv
// Two-stage pipelined mantissa aligner for the floating-point adder.
// S1 picks the common exponent and orders the operands by exponent.
// S2 right-shifts the smaller mantissa with sticky collection and routes
// both mantissas back to their A/B positions.
module alineador_mantisas_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int GRS_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W-1:0]       exp_a,
    input  logic [EXP_W-1:0]       exp_b,
    input  logic [MAN_W-1:0]       man_a,
    input  logic [MAN_W-1:0]       man_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       exp_comun,
    output logic [MAN_W+GRS_W-1:0] man_a_al,
    output logic [MAN_W+GRS_W-1:0] man_b_al,
    output logic                   a_mayor,
    output logic                   desplaz_sat
);

    localparam int EXT_W = MAN_W + GRS_W;

    // Stage-1 state
    logic             v1;
    logic [EXP_W-1:0] s1_exp;
    logic             s1_a_mayor;
    logic [EXP_W-1:0] s1_diff;
    logic [EXT_W-1:0] s1_big;
    logic [EXT_W-1:0] s1_small;

    // Stage-2 valid; the S2 data registers are the outputs themselves
    logic v2;

    logic adv1;
    logic adv2;

    // Stall chain: a stage advances if it is empty or the stage after it advances
    always_comb begin
        adv2     = !v2 || out_ready;
        adv1     = !v1 || adv2;
        in_ready = adv1;
    end

    assign out_valid = v2;

    // Exponent comparison: sign of the (EXP_W+1)-bit difference decides the order
    logic [EXP_W:0]   diff_raw;
    logic             exp_a_ge;
    logic [EXP_W-1:0] diff_mag;

    always_comb begin
        diff_raw = {1'b0, exp_a} - {1'b0, exp_b};
        exp_a_ge = !diff_raw[EXP_W];
        diff_mag = exp_a_ge ? (exp_a - exp_b) : (exp_b - exp_a);
    end

    // S1 register: common exponent, ordering flag, distance, extended mantissas
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values; blocking here would create ordering races.
        if (rst) begin
            v1         <= 1'b0;
            s1_exp     <= '0;
            s1_a_mayor <= 1'b0;
            s1_diff    <= '0;
            s1_big     <= '0;
            s1_small   <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_exp     <= exp_a_ge ? exp_a : exp_b;
                s1_a_mayor <= exp_a_ge;
                s1_diff    <= diff_mag;
                s1_big     <= exp_a_ge ? {man_a, GRS_W'(0)} : {man_b, GRS_W'(0)};
                s1_small   <= exp_a_ge ? {man_b, GRS_W'(0)} : {man_a, GRS_W'(0)};
            end
        end
    end

    // Right shift of the smaller mantissa with sticky; saturates to the OR of all bits
    logic             sat;
    logic [EXT_W-1:0] shifted;
    logic [EXT_W-1:0] lost_mask;
    logic [EXT_W-1:0] small_al;

    always_comb begin
        // NOTE: every signal of this block is assigned before any conditional,
        // so no path leaves a value unassigned and no latch is inferred.
        sat       = 32'(s1_diff) >= 32'(EXT_W);
        shifted   = s1_small >> s1_diff;
        lost_mask = ~({EXT_W{1'b1}} << s1_diff);
        small_al  = {shifted[EXT_W-1:1],
                     shifted[0] | (|(s1_small & lost_mask)) | s1_small[0]};
        if (sat) begin
            small_al = {{(EXT_W-1){1'b0}}, |s1_small};
        end
    end

    // S2 register: aligned pair back in A/B order, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2          <= 1'b0;
            exp_comun   <= '0;
            a_mayor     <= 1'b0;
            desplaz_sat <= 1'b0;
            man_a_al    <= '0;
            man_b_al    <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                exp_comun   <= s1_exp;
                a_mayor     <= s1_a_mayor;
                desplaz_sat <= sat;
                man_a_al    <= s1_a_mayor ? s1_big : small_al;
                man_b_al    <= s1_a_mayor ? small_al : s1_big;
            end
        end
    end

endmodule
